thermo_window_tx: RTL and testbench
===================================

// Module: thermo_window_tx
// PURPOSE
//   Transmit side of the pooling-filter datapath: accepts a stream of N_BITS-wide binary
//   samples and encodes each one to a (2**N_BITS-1)-bit thermometer code.
//   Groups four samples into one 2x2 pooling window and presents them as four parallel codes.
//   The window is handed to the thermometer second-largest (majority) stage over a valid/ready handshake.
//   Sits between the pixel/sample source and the combinational pooling comparator.
// PARAMETERS
//   N_BITS    4    binary sample width
//   THERMO_W  15   derived localparam, 2**N_BITS-1; thermometer code width
// PORTS
//   clk        in   1         rising-edge clock
//   rst        in   1         synchronous reset, active-high
//   s_valid    in   1         input sample valid
//   s_ready    out  1         block can accept a sample this cycle
//   s_data     in   N_BITS    binary sample value
//   s_last     in   1         final sample of the frame; closes the window early
//   m_valid    out  1         window codes valid
//   m_ready    in   1         downstream accepts the window
//   m_code1    out  THERMO_W  thermometer code of slot 0 (first sample)
//   m_code2    out  THERMO_W  thermometer code of slot 1
//   m_code3    out  THERMO_W  thermometer code of slot 2
//   m_code4    out  THERMO_W  thermometer code of slot 3 (last sample)
//   m_padded   out  1         window contains zero-padded slots (closed by s_last)
//   m_win_cnt  out  8         count of windows handed off; wraps modulo 256
// BEHAVIOUR
//   Encoding: for value v, code bit k = 1 iff k < v (LSB-filled).
//     v=0 -> all zeros; v=15 -> 15'h7FFF; v=4 -> 15'h000F.
//   FSM, two states:
//     FILL: s_ready=1; slot index idx runs 0..3.
//       On s_valid&&s_ready, write the encoded s_data into slot idx.
//       idx==3, or s_last=1 -> go to SEND. Otherwise idx+1.
//     Early close (s_last with idx<3): slots idx+1..3 load 0, m_padded=1.
//       Otherwise m_padded=0.
//     SEND: s_ready=0, m_valid=1; m_code1..4 and m_padded held stable.
//       On m_valid&&m_ready: m_win_cnt+1, idx=0, go to FILL.
//       Codes keep their last value in FILL; m_valid=0 there.
//   Latency: m_valid rises the cycle after the handshake that fills slot 3 (or carries s_last).
//   Throughput: no overlap of fill and send.
//     Minimum 5 cycles per full window (4 accepts plus 1 send with m_ready=1).
//   Backpressure: m_ready=0 in SEND holds everything indefinitely; no sample is accepted or lost.
//   s_ready depends only on state and rst; it never depends on s_valid or m_ready.
//   s_last is ignored unless s_valid&&s_ready.
//   s_last on the slot-3 sample is a normal full window, m_padded=0.
//   m_win_cnt: 8-bit unsigned, 255 -> 0 on the next handoff.
//   Reset: while rst=1, s_ready=0 and m_valid=0.
//     Next cycle state=FILL, idx=0, m_code1..4=0, m_padded=0, m_win_cnt=0.
//   Reset mid-fill or mid-send discards the partial or pending window; nothing is emitted.
//   Outputs are registered only; no combinational path from s_* to m_*.
// TESTING
//   1 Feed 1,2,4,15 (m_ready=1) -> codes 0x0001,0x0003,0x000F,0x7FFF; m_valid 1 cycle after 4th accept.
//     Expect m_padded=0 and m_win_cnt=1. Attached thermo majority stage outputs 4'b0100.
//   2 Feed 7,10,11,0 with m_ready=0 for 10 cycles -> m_valid=1 and codes 0x007F,0x03FF,0x07FF,0x0000 stable.
//     Expect s_ready=0 throughout. Raise m_ready -> exactly one handoff.
//   3 Feed 9, then 3 with s_last=1 -> codes 0x01FF,0x0007,0x0000,0x0000, m_padded=1.
//     Next window starts at slot 0.
//   4 Feed a single sample 15 with s_last=1 -> codes 0x7FFF,0,0,0, m_padded=1.
//   5 Accept 2 samples, assert rst for 1 cycle, then feed 2,2,2,2 -> one window of four 0x0003.
//     Expect no stale slot data and m_win_cnt=1.
//   6 Stream 256 full windows with random s_valid/m_ready gaps -> m_win_cnt wraps to 0.
//     Scoreboard matches every code against a reference encoder.

Source files
------------

// File: rtl/thermo_window_tx.sv
// Thermometer-encodes binary samples and groups four into one 2x2 pooling window
// handed downstream over a valid/ready handshake.
module thermo_window_tx #(
  parameter int N_BITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [N_BITS-1:0]       s_data,
  input  logic                    s_last,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [2**N_BITS-2:0]    m_code1,
  output logic [2**N_BITS-2:0]    m_code2,
  output logic [2**N_BITS-2:0]    m_code3,
  output logic [2**N_BITS-2:0]    m_code4,
  output logic                    m_padded,
  output logic [7:0]              m_win_cnt
);

  localparam int THERMO_W = 2**N_BITS - 1;

  typedef enum logic {FILL, SEND} state_t;

  state_t                state;
  logic [1:0]            idx;
  logic [THERMO_W-1:0]   slot [4];
  logic                  padded;
  logic [7:0]            win_cnt;
  logic [THERMO_W-1:0]   enc;
  logic                  close;

  function automatic logic [THERMO_W-1:0] therm(input logic [N_BITS-1:0] v);
    logic [THERMO_W-1:0] r;
    r = '0;
    for (int k = 0; k < THERMO_W; k++) begin
      r[k] = (k < int'(v));
    end
    return r;
  endfunction

  assign enc   = therm(s_data);
  assign close = (idx == 2'd3) || s_last;

  // Handshake flags follow state only; rst forces both low while held.
  assign s_ready = (state == FILL) && !rst;
  assign m_valid = (state == SEND) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= FILL;
      idx     <= 2'd0;
      padded  <= 1'b0;
      win_cnt <= 8'd0;
      for (int j = 0; j < 4; j++) begin
        slot[j] <= '0;
      end
    end else begin
      unique case (state)
        FILL: begin
          if (s_valid) begin
            for (int j = 0; j < 4; j++) begin
              if (j == int'(idx)) begin
                slot[j] <= enc;
              end else if (s_last && j > int'(idx)) begin
                slot[j] <= '0;
              end
            end
            if (close) begin
              padded <= (idx != 2'd3);
              idx    <= 2'd0;
              state  <= SEND;
            end else begin
              idx <= idx + 2'd1;
            end
          end
        end
        SEND: begin
          if (m_ready) begin
            win_cnt <= win_cnt + 8'd1;
            state   <= FILL;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  assign m_code1   = slot[0];
  assign m_code2   = slot[1];
  assign m_code3   = slot[2];
  assign m_code4   = slot[3];
  assign m_padded  = padded;
  assign m_win_cnt = win_cnt;

endmodule

// File: tb/tb_thermo_window_tx.sv
// Randomised and directed bench for thermo_window_tx against a
// queue-based window model with an arithmetic thermometer encoder.
module tb_thermo_window_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid;
  logic        s_ready;
  logic [3:0]  s_data;
  logic        s_last;
  logic        m_valid;
  logic        m_ready;
  logic [14:0] m_code1, m_code2, m_code3, m_code4;
  logic        m_padded;
  logic [7:0]  m_win_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_cnt  = 0;

  logic [59:0] exp_q [$];

  always #5 clk = ~clk;

  thermo_window_tx dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready),
    .m_code1(m_code1), .m_code2(m_code2), .m_code3(m_code3), .m_code4(m_code4),
    .m_padded(m_padded), .m_win_cnt(m_win_cnt)
  );

  function automatic logic [14:0] exp_code(input int v);
    return 15'((32'd1 << v) - 32'd1);
  endfunction

  function automatic logic [59:0] exp_win(input int a, b, c, d);
    return {exp_code(d), exp_code(c), exp_code(b), exp_code(a)};
  endfunction

  task automatic put_sample(input int v, input bit last);
    int g = 0;
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = 4'(v);
    s_last  = last;
    while (!s_ready && g < 200) begin
      @(negedge clk);
      g++;
    end
    n_checks++;
    if (!s_ready) begin
      n_fail++;
      $display("FAIL put_timeout: s_ready=%b after %0d cycles, required 1", s_ready, g);
    end
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (s_ready !== 1'b0 || m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hs: s_ready=%b m_valid=%b, required 0 0", s_ready, m_valid);
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({m_code1, m_code2, m_code3, m_code4} !== 60'd0 || m_padded !== 1'b0 ||
        m_win_cnt !== 8'd0 || s_ready !== 1'b1 || m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: codes=%h pad=%b cnt=%0d s_ready=%b m_valid=%b, required 0 0 0 1 0",
               {m_code4, m_code3, m_code2, m_code1}, m_padded, m_win_cnt, s_ready, m_valid);
    end
    exp_cnt = 0;
  endtask

  task automatic test_full_window();
    int pc [4];
    int t;
    m_ready = 1'b1;
    put_sample(1, 0);
    put_sample(2, 0);
    put_sample(4, 0);
    put_sample(15, 0);
    idle();
    n_checks++;
    if (m_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL full_latency: m_valid=%b, required 1", m_valid);
    end
    n_checks++;
    if ({m_code4, m_code3, m_code2, m_code1} !== exp_win(1, 2, 4, 15) || m_padded !== 1'b0) begin
      n_fail++;
      $display("FAIL full_codes: %h pad=%b, required %h pad=0",
               {m_code4, m_code3, m_code2, m_code1}, m_padded, exp_win(1, 2, 4, 15));
    end
    pc[0] = $countones(m_code1);
    pc[1] = $countones(m_code2);
    pc[2] = $countones(m_code3);
    pc[3] = $countones(m_code4);
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 3 - i; j++) begin
        if (pc[j] < pc[j+1]) begin
          t = pc[j]; pc[j] = pc[j+1]; pc[j+1] = t;
        end
      end
    end
    n_checks++;
    if (4'(pc[1]) !== 4'b0100) begin
      n_fail++;
      $display("FAIL full_majority: %b, required 0100", 4'(pc[1]));
    end
    @(negedge clk);
    exp_cnt++;
    n_checks++;
    if (m_valid !== 1'b0 || m_win_cnt !== 8'(exp_cnt)) begin
      n_fail++;
      $display("FAIL full_handoff: m_valid=%b cnt=%0d, required 0 %0d", m_valid, m_win_cnt, exp_cnt);
    end
  endtask

  task automatic test_backpressure();
    logic [59:0] w;
    m_ready = 1'b0;
    w = exp_win(7, 10, 11, 0);
    put_sample(7, 0);
    put_sample(10, 0);
    put_sample(11, 0);
    put_sample(0, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = 4'd5;
      n_checks++;
      if (m_valid !== 1'b1 || s_ready !== 1'b0 ||
          {m_code4, m_code3, m_code2, m_code1} !== w || m_win_cnt !== 8'(exp_cnt)) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: m_valid=%b s_ready=%b codes=%h cnt=%0d, required 1 0 %h %0d",
                 i, m_valid, s_ready, {m_code4, m_code3, m_code2, m_code1}, m_win_cnt, w, exp_cnt);
      end
    end
    @(negedge clk);
    s_valid = 1'b0;
    m_ready = 1'b1;
    @(negedge clk);
    exp_cnt++;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (m_valid !== 1'b0 || m_win_cnt !== 8'(exp_cnt)) begin
        n_fail++;
        $display("FAIL bp_release[%0d]: m_valid=%b cnt=%0d, required 0 %0d", i, m_valid, m_win_cnt, exp_cnt);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_early_close();
    m_ready = 1'b1;
    put_sample(9, 0);
    put_sample(3, 1);
    idle();
    n_checks++;
    if (m_valid !== 1'b1 || m_padded !== 1'b1 ||
        {m_code4, m_code3, m_code2, m_code1} !== exp_win(9, 3, 0, 0)) begin
      n_fail++;
      $display("FAIL early_close: m_valid=%b pad=%b codes=%h, required 1 1 %h",
               m_valid, m_padded, {m_code4, m_code3, m_code2, m_code1}, exp_win(9, 3, 0, 0));
    end
    @(negedge clk);
    exp_cnt++;
    n_checks++;
    if (m_win_cnt !== 8'(exp_cnt)) begin
      n_fail++;
      $display("FAIL early_cnt: %0d, required %0d", m_win_cnt, exp_cnt);
    end
  endtask

  task automatic test_single_last();
    put_sample(15, 1);
    idle();
    n_checks++;
    if (m_valid !== 1'b1 || m_padded !== 1'b1 ||
        {m_code4, m_code3, m_code2, m_code1} !== {45'd0, 15'h7FFF}) begin
      n_fail++;
      $display("FAIL single_last: m_valid=%b pad=%b codes=%h, required 1 1 %h",
               m_valid, m_padded, {m_code4, m_code3, m_code2, m_code1}, {45'd0, 15'h7FFF});
    end
    @(negedge clk);
    exp_cnt++;
    put_sample(6, 0);
    put_sample(8, 0);
    put_sample(13, 0);
    put_sample(14, 1);
    idle();
    n_checks++;
    if (m_padded !== 1'b0 || {m_code4, m_code3, m_code2, m_code1} !== exp_win(6, 8, 13, 14)) begin
      n_fail++;
      $display("FAIL last_on_slot3: pad=%b codes=%h, required 0 %h",
               m_padded, {m_code4, m_code3, m_code2, m_code1}, exp_win(6, 8, 13, 14));
    end
    @(negedge clk);
    exp_cnt++;
  endtask

  task automatic test_reset_mid_fill();
    m_ready = 1'b1;
    put_sample(11, 0);
    put_sample(12, 0);
    @(negedge clk);
    s_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (s_ready !== 1'b0 || m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_hs: s_ready=%b m_valid=%b, required 0 0", s_ready, m_valid);
    end
    rst = 1'b0;
    exp_cnt = 0;
    @(negedge clk);
    n_checks++;
    if (m_code1 !== 15'd0 || m_code2 !== 15'd0 || m_win_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL rst_mid_clear: c1=%h c2=%h cnt=%0d, required 0 0 0", m_code1, m_code2, m_win_cnt);
    end
    for (int i = 0; i < 4; i++) put_sample(2, 0);
    idle();
    n_checks++;
    if (m_valid !== 1'b1 || m_padded !== 1'b0 ||
        {m_code4, m_code3, m_code2, m_code1} !== exp_win(2, 2, 2, 2)) begin
      n_fail++;
      $display("FAIL rst_mid_win: m_valid=%b pad=%b codes=%h, required 1 0 %h",
               m_valid, m_padded, {m_code4, m_code3, m_code2, m_code1}, exp_win(2, 2, 2, 2));
    end
    @(negedge clk);
    exp_cnt++;
    n_checks++;
    if (m_win_cnt !== 8'(exp_cnt)) begin
      n_fail++;
      $display("FAIL rst_mid_cnt: %0d, required %0d", m_win_cnt, exp_cnt);
    end
  endtask

  task automatic test_random_wrap();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 0;
    exp_q.delete();
    fork
      begin : producer
        int n = 0;
        int g = 0;
        int v = $urandom_range(15);
        int vals [4];
        while (n < 1024 && g < 40000) begin
          @(negedge clk);
          g++;
          s_last = 1'b0;
          if ($urandom_range(1) == 1) begin
            s_valid = 1'b1;
            s_data  = 4'(v);
          end else begin
            s_valid = 1'b0;
          end
          if (s_valid && s_ready) begin
            vals[n % 4] = v;
            if (n % 4 == 3) exp_q.push_back(exp_win(vals[0], vals[1], vals[2], vals[3]));
            n++;
            v = $urandom_range(15);
          end
        end
        @(negedge clk);
        s_valid = 1'b0;
        n_checks++;
        if (n != 1024) begin
          n_fail++;
          $display("FAIL rand_producer_timeout: accepted %0d, required 1024", n);
        end
      end
      begin : consumer
        int got = 0;
        int g = 0;
        logic [59:0] w;
        while (got < 256 && g < 45000) begin
          @(negedge clk);
          g++;
          m_ready = ($urandom_range(2) != 0);
          if (m_valid && m_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
              n_fail++;
              $display("FAIL rand_unexpected_window: got %h with empty model queue",
                       {m_code4, m_code3, m_code2, m_code1});
            end else begin
              w = exp_q.pop_front();
              if ({m_code4, m_code3, m_code2, m_code1} !== w || m_padded !== 1'b0 ||
                  m_win_cnt !== 8'(exp_cnt)) begin
                n_fail++;
                $display("FAIL rand_win[%0d]: codes=%h pad=%b cnt=%0d, required %h 0 %0d",
                         got, {m_code4, m_code3, m_code2, m_code1}, m_padded, m_win_cnt, w, exp_cnt);
              end
            end
            exp_cnt++;
            got++;
          end
        end
        n_checks++;
        if (got != 256) begin
          n_fail++;
          $display("FAIL rand_consumer_timeout: windows %0d, required 256", got);
        end
      end
    join
    @(negedge clk);
    n_checks++;
    if (m_win_cnt !== 8'(exp_cnt) || m_win_cnt !== 8'd0 || m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rand_wrap: cnt=%0d m_valid=%b, required 0 0", m_win_cnt, m_valid);
    end
  endtask

  initial begin
    rst     = 1'b1;
    s_valid = 1'b0;
    s_data  = 4'd0;
    s_last  = 1'b0;
    m_ready = 1'b0;
    test_reset();
    test_full_window();
    test_backpressure();
    test_early_close();
    test_single_last();
    test_reset_mid_fill();
    test_random_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
